keccak_ctrl: RTL and testbench
==============================

Name: keccak_ctrl

Overview:
- Sequencing controller for the step-mapped Keccak datapath (256-bit data words, one permutation step per cycle).
- Clears the state, steers absorb of 32-byte input beats into the rate, and issues the pad command.
- Runs 24 rounds × 5 steps per permutation, then drives squeeze beats for the SHA3-256, SHA3-512, SHAKE128 and SHAKE256 modes.
- Sits between the message stream/output stream and the state-array datapath.

Parameters:
- MAX_ROUNDS, 24, rounds per permutation
- DWIDTH, 256, data beat width in bits (32 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin new hash; ignored unless idle
- mode  in  2  0=SHA3_256, 1=SHA3_512, 2=SHAKE128, 3=SHAKE256; latched on accepted start
- in_valid  in  1  input beat valid
- in_ready  out  1  controller accepts beat
- in_last  in  1  final message beat; 0-byte last beat allowed
- in_bytes  in  6  valid bytes in beat, 0..32
- rate_rem  out  8  bytes left in current rate block (rate − byte_off)
- stop  in  1  ends SHAKE squeeze
- out_valid  out  1  squeeze beat valid
- out_ready  in  1  downstream accepts
- out_bytes  out  6  valid bytes in squeeze beat
- byte_off  out  8  rate byte offset for absorb/pad/squeeze
- absorb_en  out  1  datapath XORs beat at byte_off
- pad_en  out  1  datapath XORs pad_dom at byte_off and 0x80 at rate−1
- pad_dom  out  8  0x06 for SHA3 modes, 0x1F for SHAKE modes
- step_sel  out  3  0=ZERO, 1=THETA, 2=RHO, 3=PI, 4=CHI, 5=IOTA
- round_idx  out  5  current round, 0..23
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky protocol error, cleared on accepted start

Behaviour:
- Rate bytes: SHA3_256=136, SHA3_512=72, SHAKE128=168, SHAKE256=136.
- Reset (async, any state): state=IDLE, byte_off=0, counters=0, err=0, every output 0 (step_sel=ZERO).
- FSM states: IDLE, CLEAR, ABSORB, PAD, PERMUTE, SQUEEZE.
- IDLE:
  - start → CLEAR.
  - Latches mode; clears err, byte_off and output byte count.
- CLEAR:
  - 1 cycle, step_sel=ZERO (zeroes state) → ABSORB.
- ABSORB:
  - in_ready=1; absorb_en=in_valid in the same cycle.
  - Handshake: byte_off += in_bytes.
  - in_bytes > rate_rem: beat dropped (absorb_en=0), err=1, → IDLE, no done.
  - Post-add byte_off==rate, !in_last → PERMUTE, return ABSORB.
  - in_last and byte_off==rate → PERMUTE, return PAD.
  - in_last otherwise → PAD.
- PAD:
  - 1 cycle, pad_en=1 at current byte_off (byte rate−1 gets pad_dom|0x80) → PERMUTE, return SQUEEZE.
- PERMUTE:
  - Exactly 120 cycles, step_sel cycles THETA,RHO,PI,CHI,IOTA; round_idx increments after IOTA.
  - byte_off←0 on entry; in_ready=0, out_valid=0.
  - Exit to latched return state after round 23 IOTA.
- SQUEEZE:
  - out_valid=1.
  - out_bytes = min(32, rate−byte_off, remaining) for SHA3 modes (total 32 / 64 bytes); min(32, rate−byte_off) for SHAKE.
  - Handshake: byte_off += out_bytes.
  - SHA3 total reached → done, IDLE.
  - byte_off==rate → PERMUTE, return SQUEEZE.
  - SHAKE: stop=1 → done, IDLE. A handshake in the same cycle completes first.
  - out_valid holds with stable out_bytes/byte_off until accepted.
- busy=1 in all states except IDLE; start while busy ignored.

Test Plan:
- SHA3_256, empty message (in_last, in_bytes=0) → CLEAR 1 cycle; PAD byte_off=0 pad_dom=0x06; 120 PERMUTE cycles; one beat out_bytes=32; done pulses; total beats exact.
- SHA3_512, beats 32,32,8 (last) → off reaches 72 → PERMUTE, then PAD at byte_off=0, PERMUTE; out beats 32 (off 0), 32 (off 32); done.
- SHAKE128, 5 squeeze beats then continue → out_bytes 32,32,32,32,32,8 (off 160); re-PERMUTE; next beat off=0; stop → done.
- Step checker over a permutation → step_sel sequence 1..5 repeated 24 times; round_idx 0..23 valid with IOTA; 120 cycles exactly.
- Violation: SHA3_256 after 128 bytes, send in_bytes=32 (rate_rem=8) → absorb_en=0, err=1, IDLE, no done; next start clears err.
- Reset asserted mid-PERMUTE round 10 → all outputs 0 immediately; next start runs a clean CLEAR.

Source files
------------

// File: rtl/keccak_ctrl.sv
// Sequencing controller for a step-mapped Keccak datapath: clears the state,
// steers absorb/pad, runs 24x5 permutation steps and paces squeeze beats.
module keccak_ctrl #(
  parameter int MAX_ROUNDS = 24,
  parameter int DWIDTH     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic [5:0] in_bytes,
  output logic [7:0] rate_rem,
  input  logic       stop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_bytes,
  output logic [7:0] byte_off,
  output logic       absorb_en,
  output logic       pad_en,
  output logic [7:0] pad_dom,
  output logic [2:0] step_sel,
  output logic [4:0] round_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ABSORB, S_PAD, S_PERMUTE, S_SQUEEZE
  } state_t;

  localparam logic [7:0] BEAT_BYTES = 8'(DWIDTH / 8);
  localparam logic [2:0] STEP_ZERO  = 3'd0;
  localparam logic [2:0] STEP_THETA = 3'd1;
  localparam logic [2:0] STEP_IOTA  = 3'd5;
  localparam logic [4:0] LAST_ROUND = 5'(MAX_ROUNDS - 1);

  state_t     state_q, state_d, ret_q, ret_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] byte_off_q, byte_off_d;
  logic [7:0] out_cnt_q, out_cnt_d;
  logic [2:0] step_q, step_d;
  logic [4:0] round_q, round_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  logic [7:0] rate, rate_left, total, sq_rem, sq_bytes, cnt_sum;
  logic [8:0] abs_sum, sq_sum;
  logic       sha3, beat_too_big;

  always_comb begin
    case (mode_q)
      2'd0:    rate = 8'd136;
      2'd1:    rate = 8'd72;
      2'd2:    rate = 8'd168;
      default: rate = 8'd136;
    endcase
  end

  assign sha3         = !mode_q[1];
  assign total        = mode_q[0] ? 8'd64 : 8'd32;
  assign rate_left    = rate - byte_off_q;
  assign sq_rem       = total - out_cnt_q;
  assign beat_too_big = {2'b00, in_bytes} > rate_left;
  assign abs_sum      = {1'b0, byte_off_q} + {3'b000, in_bytes};
  assign sq_sum       = {1'b0, byte_off_q} + {1'b0, sq_bytes};
  assign cnt_sum      = out_cnt_q + sq_bytes;

  // Squeeze beat size: a full beat, clipped by the rate block and, for the
  // fixed-length SHA3 digests, by the digest bytes still owed.
  always_comb begin
    sq_bytes = BEAT_BYTES;
    if (rate_left < sq_bytes) sq_bytes = rate_left;
    if (sha3 && (sq_rem < sq_bytes)) sq_bytes = sq_rem;
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    mode_d     = mode_q;
    byte_off_d = byte_off_q;
    out_cnt_d  = out_cnt_q;
    step_d     = step_q;
    round_d    = round_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          mode_d     = mode;
          err_d      = 1'b0;
          byte_off_d = 8'd0;
          out_cnt_d  = 8'd0;
        end
      end
      S_CLEAR: state_d = S_ABSORB;
      S_ABSORB: begin
        if (in_valid) begin
          if (beat_too_big) begin
            err_d      = 1'b1;
            state_d    = S_IDLE;
            byte_off_d = 8'd0;
          end else if (abs_sum == {1'b0, rate}) begin
            state_d    = S_PERMUTE;
            ret_d      = in_last ? S_PAD : S_ABSORB;
            byte_off_d = 8'd0;
            step_d     = STEP_THETA;
            round_d    = 5'd0;
          end else begin
            byte_off_d = abs_sum[7:0];
            if (in_last) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        state_d    = S_PERMUTE;
        ret_d      = S_SQUEEZE;
        byte_off_d = 8'd0;
        step_d     = STEP_THETA;
        round_d    = 5'd0;
      end
      S_PERMUTE: begin
        if (step_q == STEP_IOTA) begin
          step_d = STEP_THETA;
          if (round_q == LAST_ROUND) begin
            round_d = 5'd0;
            step_d  = STEP_ZERO;
            state_d = ret_q;
          end else begin
            round_d = round_q + 5'd1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_SQUEEZE: begin
        if (out_ready) begin
          byte_off_d = sq_sum[7:0];
          if (sha3) out_cnt_d = cnt_sum;
          // A SHAKE stop alongside a handshake lets that beat go first.
          if ((sha3 && cnt_sum == total) || (!sha3 && stop)) begin
            done_d     = 1'b1;
            state_d    = S_IDLE;
            byte_off_d = 8'd0;
          end else if (sq_sum == {1'b0, rate}) begin
            state_d    = S_PERMUTE;
            ret_d      = S_SQUEEZE;
            byte_off_d = 8'd0;
            step_d     = STEP_THETA;
            round_d    = 5'd0;
          end
        end else if (!sha3 && stop) begin
          done_d     = 1'b1;
          state_d    = S_IDLE;
          byte_off_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      mode_q     <= 2'd0;
      byte_off_q <= 8'd0;
      out_cnt_q  <= 8'd0;
      step_q     <= STEP_ZERO;
      round_q    <= 5'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      mode_q     <= mode_d;
      byte_off_q <= byte_off_d;
      out_cnt_q  <= out_cnt_d;
      step_q     <= step_d;
      round_q    <= round_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ABSORB);
  assign absorb_en = in_ready && in_valid && !beat_too_big;
  assign pad_en    = (state_q == S_PAD);
  assign pad_dom   = busy ? (mode_q[1] ? 8'h1F : 8'h06) : 8'h00;
  assign out_valid = (state_q == S_SQUEEZE);
  assign out_bytes = out_valid ? sq_bytes[5:0] : 6'd0;
  assign rate_rem  = busy ? rate_left : 8'd0;
  assign byte_off  = byte_off_q;
  assign step_sel  = step_q;
  assign round_idx = round_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keccak_ctrl.sv
// Scenario bench for keccak_ctrl: squeeze beats are checked against a queue
// of expected {out_bytes, byte_off} entries pushed by each scenario.
module tb_keccak_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [5:0] in_bytes = 6'd0;
  logic       stop = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, absorb_en, pad_en, busy, done, err;
  logic [7:0] rate_rem, byte_off, pad_dom;
  logic [5:0] out_bytes;
  logic [2:0] step_sel;
  logic [4:0] round_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];

  keccak_ctrl #(.MAX_ROUNDS(24), .DWIDTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_bytes(in_bytes), .rate_rem(rate_rem), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
    .byte_off(byte_off), .absorb_en(absorb_en), .pad_en(pad_en),
    .pad_dom(pad_dom), .step_sel(step_sel), .round_idx(round_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_hash(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int nb, input bit last);
    in_valid = 1'b1;
    in_bytes = 6'(nb);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_bytes = 6'd0;
    in_last  = 1'b0;
  endtask

  // Walks a permutation from its first cycle, counting cycles and any cycle
  // whose step/round disagrees with THETA..IOTA x 24.
  task automatic wait_permute(output int cyc, output int seq_err);
    cyc = 0;
    seq_err = 0;
    while (step_sel != 3'd0 && cyc < 300) begin
      if (step_sel !== 3'(cyc % 5 + 1) || round_idx !== 5'(cyc / 5) ||
          busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
        seq_err++;
      cyc++;
      tick();
    end
  endtask

  task automatic drain(input int stop_at, output int beats, output int perm_cyc,
                       output bit got_done);
    int cyc;
    logic [13:0] e;
    cyc = 0;
    beats = 0;
    perm_cyc = 0;
    got_done = 1'b0;
    out_ready = 1'b1;
    while (!got_done && cyc < 1000) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (step_sel != 3'd0) perm_cyc++;
        if (out_valid === 1'b1) begin
          beats++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sq_beat unexpected beat bytes=%0d off=%0d", out_bytes, byte_off);
          end else begin
            e = exp_q.pop_front();
            if ({out_bytes, byte_off} !== e) begin
              n_fail++;
              $display("FAIL sq_beat%0d got bytes=%0d off=%0d want bytes=%0d off=%0d",
                       beats, out_bytes, byte_off, e[13:8], e[7:0]);
            end
          end
          if (stop_at != 0 && beats == stop_at) stop = 1'b1;
        end
        cyc++;
        tick();
        stop = 1'b0;
      end
    end
    out_ready = 1'b0;
    n_tests++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL drain_done no done within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({busy, in_ready, out_valid, absorb_en, pad_en, done, err, step_sel, round_idx,
         byte_off, rate_rem, out_bytes, pad_dom} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs busy=%b step=%0d off=%0d rate_rem=%0d pad_dom=%h want all 0",
               busy, step_sel, byte_off, rate_rem, pad_dom);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_sha3_256_empty();
    int cyc, se, beats, pc;
    bit gd;
    start_hash(2'd0);
    n_tests++;
    if ({busy, in_ready, out_valid, pad_en, step_sel} !== {4'b1000, 3'd0}) begin
      n_fail++;
      $display("FAIL e256_clear busy=%b rdy=%b step=%0d want busy=1 rdy=0 step=0",
               busy, in_ready, step_sel);
    end
    tick();
    n_tests++;
    if ({in_ready, rate_rem, byte_off} !== {1'b1, 8'd136, 8'd0}) begin
      n_fail++;
      $display("FAIL e256_absorb rdy=%b rate_rem=%0d off=%0d want 1/136/0",
               in_ready, rate_rem, byte_off);
    end
    in_valid = 1'b1; in_last = 1'b1; in_bytes = 6'd0;
    #1;
    n_tests++;
    if (absorb_en !== 1'b1) begin
      n_fail++;
      $display("FAIL e256_absorb_en got %b want 1", absorb_en);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_tests++;
    if ({pad_en, byte_off, pad_dom} !== {1'b1, 8'd0, 8'h06}) begin
      n_fail++;
      $display("FAIL e256_pad pad_en=%b off=%0d dom=%h want 1/0/06", pad_en, byte_off, pad_dom);
    end
    tick();
    wait_permute(cyc, se);
    n_tests++;
    if (cyc != 120 || se != 0) begin
      n_fail++;
      $display("FAIL e256_permute cycles=%0d step_errs=%0d want 120/0", cyc, se);
    end
    exp_q.push_back({6'd32, 8'd0});
    drain(0, beats, pc, gd);
    n_tests++;
    if (beats != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL e256_beats got %0d left=%0d want 1/0", beats, exp_q.size());
    end
    tick();
    n_tests++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL e256_done_pulse done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_sha3_512();
    int cyc, se, beats, pc;
    bit gd;
    start_hash(2'd1);
    tick();
    n_tests++;
    if (rate_rem !== 8'd72) begin
      n_fail++;
      $display("FAIL s512_rate got %0d want 72", rate_rem);
    end
    send_beat(32, 1'b0);
    n_tests++;
    if ({byte_off, rate_rem, in_ready} !== {8'd32, 8'd40, 1'b1}) begin
      n_fail++;
      $display("FAIL s512_beat1 off=%0d rem=%0d rdy=%b want 32/40/1", byte_off, rate_rem, in_ready);
    end
    // start while busy must not re-latch the mode
    start = 1'b1; mode = 2'd3;
    send_beat(32, 1'b0);
    start = 1'b0;
    n_tests++;
    if ({byte_off, rate_rem, pad_dom} !== {8'd64, 8'd8, 8'h06}) begin
      n_fail++;
      $display("FAIL s512_beat2 off=%0d rem=%0d dom=%h want 64/8/06", byte_off, rate_rem, pad_dom);
    end
    send_beat(8, 1'b1);
    n_tests++;
    if ({step_sel, byte_off} !== {3'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL s512_full_block step=%0d off=%0d want 1/0", step_sel, byte_off);
    end
    wait_permute(cyc, se);
    n_tests++;
    if (cyc != 120 || se != 0) begin
      n_fail++;
      $display("FAIL s512_permute1 cycles=%0d step_errs=%0d want 120/0", cyc, se);
    end
    n_tests++;
    if ({pad_en, byte_off, pad_dom} !== {1'b1, 8'd0, 8'h06}) begin
      n_fail++;
      $display("FAIL s512_pad pad_en=%b off=%0d dom=%h want 1/0/06", pad_en, byte_off, pad_dom);
    end
    tick();
    wait_permute(cyc, se);
    n_tests++;
    if (cyc != 120 || se != 0) begin
      n_fail++;
      $display("FAIL s512_permute2 cycles=%0d step_errs=%0d want 120/0", cyc, se);
    end
    exp_q.push_back({6'd32, 8'd0});
    exp_q.push_back({6'd32, 8'd32});
    drain(0, beats, pc, gd);
    n_tests++;
    if (beats != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL s512_beats got %0d left=%0d want 2/0", beats, exp_q.size());
    end
  endtask

  task automatic test_shake128();
    int cyc, se, beats, pc;
    bit gd;
    start_hash(2'd2);
    tick();
    send_beat(10, 1'b1);
    n_tests++;
    if ({pad_en, byte_off, pad_dom} !== {1'b1, 8'd10, 8'h1F}) begin
      n_fail++;
      $display("FAIL k128_pad pad_en=%b off=%0d dom=%h want 1/10/1f", pad_en, byte_off, pad_dom);
    end
    tick();
    wait_permute(cyc, se);
    n_tests++;
    if (cyc != 120 || se != 0) begin
      n_fail++;
      $display("FAIL k128_permute cycles=%0d step_errs=%0d want 120/0", cyc, se);
    end
    out_ready = 1'b0;
    se = 0;
    for (int i = 0; i < 3; i++) begin
      if ({out_valid, out_bytes, byte_off} !== {1'b1, 6'd32, 8'd0}) se++;
      tick();
    end
    n_tests++;
    if (se != 0) begin
      n_fail++;
      $display("FAIL k128_stall unstable=%0d valid=%b bytes=%0d off=%0d want 0 1/32/0",
               se, out_valid, out_bytes, byte_off);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back({6'd32, 8'(32 * i)});
    exp_q.push_back({6'd8, 8'd160});
    exp_q.push_back({6'd32, 8'd0});
    drain(7, beats, pc, gd);
    n_tests++;
    if (beats != 7 || pc != 120 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL k128_beats beats=%0d perm=%0d left=%0d want 7/120/0", beats, pc, exp_q.size());
    end
  endtask

  task automatic test_violation();
    int cyc, se, beats, pc, dones;
    bit gd;
    start_hash(2'd0);
    tick();
    for (int i = 0; i < 4; i++) send_beat(32, 1'b0);
    n_tests++;
    if ({byte_off, rate_rem} !== {8'd128, 8'd8}) begin
      n_fail++;
      $display("FAIL viol_pre off=%0d rem=%0d want 128/8", byte_off, rate_rem);
    end
    in_valid = 1'b1; in_bytes = 6'd32;
    #1;
    n_tests++;
    if (absorb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_absorb_en got %b want 0", absorb_en);
    end
    tick();
    in_valid = 1'b0; in_bytes = 6'd0;
    dones = (done === 1'b1) ? 1 : 0;
    n_tests++;
    if ({busy, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL viol_state busy=%b err=%b want 0/1", busy, err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_no_done dones=%0d err=%b want 0/1", dones, err);
    end
    start_hash(2'd0);
    n_tests++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL viol_restart err=%b busy=%b want 0/1", err, busy);
    end
    tick();
    send_beat(0, 1'b1);
    tick();
    wait_permute(cyc, se);
    exp_q.push_back({6'd32, 8'd0});
    drain(0, beats, pc, gd);
    n_tests++;
    if (beats != 1 || cyc != 120 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL viol_rerun beats=%0d perm=%0d want 1/120", beats, cyc);
    end
  endtask

  task automatic test_reset_mid_permute();
    int k;
    start_hash(2'd3);
    tick();
    send_beat(0, 1'b1);
    tick();
    k = 0;
    while (round_idx != 5'd10 && k < 200) begin
      tick();
      k++;
    end
    n_tests++;
    if (round_idx !== 5'd10 || step_sel === 3'd0) begin
      n_fail++;
      $display("FAIL rmid_reach round=%0d step=%0d want 10/nonzero", round_idx, step_sel);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, in_ready, out_valid, absorb_en, pad_en, done, err, step_sel, round_idx,
         byte_off, rate_rem, out_bytes, pad_dom} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs busy=%b step=%0d round=%0d rem=%0d dom=%h want all 0",
               busy, step_sel, round_idx, rate_rem, pad_dom);
    end
    tick();
    rst = 1'b0;
    tick();
    start_hash(2'd3);
    n_tests++;
    if ({busy, in_ready, out_valid, step_sel, round_idx} !== {3'b100, 3'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL rmid_clear busy=%b rdy=%b step=%0d round=%0d want 1/0/0/0",
               busy, in_ready, step_sel, round_idx);
    end
    tick();
    n_tests++;
    if ({in_ready, byte_off, rate_rem, err} !== {1'b1, 8'd0, 8'd136, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_absorb rdy=%b off=%0d rem=%0d err=%b want 1/0/136/0",
               in_ready, byte_off, rate_rem, err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sha3_256_empty();
    test_sha3_512();
    test_shake128();
    test_violation();
    test_reset_mid_permute();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
